// File: rtl/ddr_phy_pkg.sv
// Shared constants and types for the DDR PHY read path.
package ddr_phy_pkg;

    localparam int NUM_PH  = 8;
    localparam int MAX_LAT = 64;
    localparam int LAT_W   = $clog2(MAX_LAT);
    // Furthest reach of the receiver-enable preamble/postamble, in phases.
    localparam int EXT     = 3;

    typedef logic [NUM_PH-1:0] ph_vec_t;
    typedef logic [LAT_W-1:0]  rd_lat_t;

    typedef enum logic {IDLE_LAT, PEND} lat_st_t;

endpackage

// File: rtl/ddr_ph_dly.sv
// Phase-granular delay line: history of input vectors plus a latency-selected window.
module ddr_ph_dly #(
    parameter int NUM_PH  = ddr_phy_pkg::NUM_PH,
    parameter int MAX_LAT = ddr_phy_pkg::MAX_LAT,
    parameter int LAT_W   = $clog2(MAX_LAT),
    parameter int EXT     = ddr_phy_pkg::EXT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [NUM_PH-1:0]       en,
    input  logic [LAT_W-1:0]        lat,
    output logic [NUM_PH+2*EXT-1:0] win,
    output logic                    in_flight
);

    localparam int DEPTH = (NUM_PH - 1 + MAX_LAT - 1 + 3 + NUM_PH - 1) / NUM_PH + 1;
    localparam int FW    = (DEPTH + 1) * NUM_PH;
    // Bit offset of the window's lowest phase when lat == 0.
    localparam int BASE  = (DEPTH - 1) * NUM_PH - EXT;

    // hist[DEPTH-1] is last cycle's input, hist[0] the oldest.
    logic [DEPTH-1:0][NUM_PH-1:0] hist;
    logic [FW-1:0]                flat;
    logic [FW-1:0]                shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      hist <= '0;
        else if (clr) hist <= '0;
        else          hist <= {en, hist[DEPTH-1:1]};
    end

    // The current input joins the flat view so the window can look ahead
    // EXT phases past the slot being registered next.
    assign flat    = {en, hist};
    assign shifted = flat >> (BASE - int'(lat));
    assign win     = shifted[NUM_PH+2*EXT-1:0];

    // Anything at or above the next output slot has not been emitted yet.
    assign in_flight = |shifted[FW-1:EXT];

endmodule

// File: rtl/ddr_rdval_gen.sv
// Read-valid generator: delays DFI rddata_en by a programmable phase latency and builds the receiver-enable window.
module ddr_rdval_gen #(
    parameter int NUM_PH  = ddr_phy_pkg::NUM_PH,
    parameter int MAX_LAT = ddr_phy_pkg::MAX_LAT,
    parameter int LAT_W   = $clog2(MAX_LAT),
    parameter int RST_LAT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_PH-1:0] i_dfi_rddata_en,
    input  logic [LAT_W-1:0]  i_rd_lat,
    input  logic              i_rd_lat_upd,
    input  logic [1:0]        i_pre,
    input  logic [1:0]        i_post,
    output logic [NUM_PH-1:0] o_rd_vld,
    output logic [NUM_PH-1:0] o_rd_ie,
    output logic [LAT_W-1:0]  o_lat_active,
    output logic              o_lat_pend,
    output logic              o_busy
);

    import ddr_phy_pkg::*;

    logic [NUM_PH+2*EXT-1:0] win;
    logic [NUM_PH-1:0]       ie_nxt;
    logic                    in_flight;
    logic                    apply;
    logic [LAT_W-1:0]        pend_lat;
    lat_st_t                 state, state_nxt;

    // History is flushed on apply so already-emitted bits cannot reappear
    // under a different window position.
    ddr_ph_dly #(
        .NUM_PH (NUM_PH),
        .MAX_LAT(MAX_LAT),
        .LAT_W  (LAT_W),
        .EXT    (EXT)
    ) u_dly (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (apply),
        .en       (i_dfi_rddata_en),
        .lat      (o_lat_active),
        .win      (win),
        .in_flight(in_flight)
    );

    // win[EXT+j] is phase j of the next output cycle; d>0 looks ahead (preamble).
    always_comb begin
        ie_nxt = '0;
        for (int j = 0; j < NUM_PH; j++)
            for (int d = -EXT; d <= EXT; d++)
                if (d >= -int'(i_post) && d <= int'(i_pre))
                    ie_nxt[j] = ie_nxt[j] | win[j+EXT+d];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_vld <= '0;
            o_rd_ie  <= '0;
        end else begin
            o_rd_vld <= win[EXT +: NUM_PH];
            o_rd_ie  <= ie_nxt;
        end
    end

    assign o_busy     = in_flight | (|o_rd_ie);
    assign o_lat_pend = (state == PEND);
    assign apply      = o_lat_pend & ~o_busy & ~(|i_dfi_rddata_en);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_LAT: if (i_rd_lat_upd) state_nxt = PEND;
            PEND:     if (apply && !i_rd_lat_upd) state_nxt = IDLE_LAT;
            default:  state_nxt = IDLE_LAT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE_LAT;
            pend_lat     <= '0;
            o_lat_active <= LAT_W'(RST_LAT);
        end else begin
            state <= state_nxt;
            // An update landing in the apply cycle stays pending; the old value applies.
            if (i_rd_lat_upd) pend_lat     <= i_rd_lat;
            if (apply)        o_lat_active <= pend_lat;
        end
    end

endmodule

// File: tb/tb_ddr_rdval_gen.sv
// Directed, table-driven bench for ddr_rdval_gen.
module tb_ddr_rdval_gen;

    import ddr_phy_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    ph_vec_t en;
    rd_lat_t rd_lat;
    logic    upd;
    logic [1:0] pre, post;
    ph_vec_t rd_vld, rd_ie;
    rd_lat_t lat_active;
    logic    lat_pend, busy;

    int checks = 0;
    int errors = 0;

    ddr_rdval_gen #(.NUM_PH(8), .MAX_LAT(64), .LAT_W(6), .RST_LAT(0)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_dfi_rddata_en(en),
        .i_rd_lat       (rd_lat),
        .i_rd_lat_upd   (upd),
        .i_pre          (pre),
        .i_post         (post),
        .o_rd_vld       (rd_vld),
        .o_rd_ie        (rd_ie),
        .o_lat_active   (lat_active),
        .o_lat_pend     (lat_pend),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Single-cycle enable at rel cycle 0; vld/ie expected at rel c0..c0+2, zero elsewhere.
    typedef struct {
        int lat; int pre; int post;
        logic [7:0] en;
        int c0;
        logic [2:0][7:0] vld;
        logic [2:0][7:0] ie;
    } vec_t;

    function automatic vec_t mk(int l, int p, int q, logic [7:0] e, int c,
                                logic [7:0] v0, logic [7:0] v1, logic [7:0] v2,
                                logic [7:0] i0, logic [7:0] i1, logic [7:0] i2);
        vec_t r;
        r.lat = l; r.pre = p; r.post = q; r.en = e; r.c0 = c;
        r.vld[0] = v0; r.vld[1] = v1; r.vld[2] = v2;
        r.ie[0]  = i0; r.ie[1]  = i1; r.ie[2]  = i2;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lat(int l);
        cyc(); rd_lat = rd_lat_t'(l); upd = 1'b1; en = '0;
        cyc(); upd = 1'b0;
        cyc(); #1;
        chk("set_lat_pend", {31'd0, lat_pend}, 32'd0);
        chk("set_lat_active", {26'd0, lat_active}, l);
    endtask

    vec_t vecs[11];

    initial begin
        int last, cnt;
        logic [7:0] ev, ei;

        vecs[0]  = mk(0,  0, 0, 8'h01, 2, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        vecs[1]  = mk(11, 0, 0, 8'h0F, 3, 8'h78, 8'h00, 8'h00, 8'h78, 8'h00, 8'h00);
        vecs[2]  = mk(13, 0, 0, 8'hFF, 3, 8'hE0, 8'h1F, 8'h00, 8'hE0, 8'h1F, 8'h00);
        vecs[3]  = mk(0,  1, 2, 8'h80, 2, 8'h80, 8'h00, 8'h00, 8'hC0, 8'h03, 8'h00);
        vecs[4]  = mk(63, 0, 0, 8'h01, 9, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00);
        vecs[5]  = mk(63, 3, 3, 8'h01, 9, 8'h80, 8'h00, 8'h00, 8'hF0, 8'h07, 8'h00);
        vecs[6]  = mk(5,  3, 0, 8'h01, 2, 8'h20, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        vecs[7]  = mk(0,  3, 0, 8'h01, 1, 8'h00, 8'h01, 8'h00, 8'hE0, 8'h01, 8'h00);
        vecs[8]  = mk(7,  0, 0, 8'h81, 2, 8'h80, 8'h40, 8'h00, 8'h80, 8'h40, 8'h00);
        vecs[9]  = mk(0,  1, 1, 8'h11, 1, 8'h00, 8'h11, 8'h00, 8'h80, 8'h3B, 8'h00);
        vecs[10] = mk(0,  0, 1, 8'h05, 2, 8'h05, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00);

        rst = 1'b1; en = '0; rd_lat = '0; upd = 1'b0; pre = '0; post = '0;
        repeat (3) cyc();
        chk("rst_vld", {24'd0, rd_vld}, 32'd0);
        chk("rst_active", {26'd0, lat_active}, 32'd0);
        rst = 1'b0;
        cyc(); #1;
        chk("rel_vld", {24'd0, rd_vld}, 32'd0);
        chk("rel_ie", {24'd0, rd_ie}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_pend", {31'd0, lat_pend}, 32'd0);

        // Single-enable vectors.
        foreach (vecs[v]) begin
            set_lat(vecs[v].lat);
            pre = 2'(vecs[v].pre); post = 2'(vecs[v].post);
            last = -1;
            for (int i = 0; i < 3; i++) if (vecs[v].ie[i] != 8'h00) last = vecs[v].c0 + i;
            for (int r = 0; r <= 12; r++) begin
                cyc();
                en = (r == 0) ? vecs[v].en : 8'h00;
                #1;
                ev = 8'h00; ei = 8'h00;
                if (r >= vecs[v].c0 && r < vecs[v].c0 + 3) begin
                    ev = vecs[v].vld[r - vecs[v].c0];
                    ei = vecs[v].ie[r - vecs[v].c0];
                end
                chk($sformatf("vec%0d_vld_r%0d", v, r), {24'd0, rd_vld}, {24'd0, ev});
                chk($sformatf("vec%0d_ie_r%0d", v, r), {24'd0, rd_ie}, {24'd0, ei});
                chk($sformatf("vec%0d_busy_r%0d", v, r), {31'd0, busy}, {31'd0, r <= last});
            end
        end

        // Continuous 20-cycle burst at L=5.
        set_lat(5); pre = '0; post = '0; cnt = 0;
        for (int r = 0; r <= 24; r++) begin
            cyc();
            en = (r < 20) ? 8'hFF : 8'h00;
            #1;
            ev = (r == 2) ? 8'hE0 : (r >= 3 && r <= 21) ? 8'hFF : (r == 22) ? 8'h1F : 8'h00;
            chk($sformatf("burst_vld_r%0d", r), {24'd0, rd_vld}, {24'd0, ev});
            cnt += $countones(rd_vld);
        end
        chk("burst_count", cnt, 160);

        // Latency update during a burst, then a second update in the apply cycle.
        cnt = 0;
        for (int r = 0; r <= 12; r++) begin
            cyc();
            en = (r < 6) ? 8'hFF : 8'h00;
            upd = (r == 2 || r == 9);
            rd_lat = (r == 2) ? rd_lat_t'(20) : rd_lat_t'(30);
            #1;
            cnt += $countones(rd_vld);
            if (r >= 3 && r <= 9) begin
                chk($sformatf("upd_pend_r%0d", r), {31'd0, lat_pend}, 32'd1);
                chk($sformatf("upd_active_r%0d", r), {26'd0, lat_active}, 32'd5);
            end
            if (r == 8) chk("upd_busy_r8", {31'd0, busy}, 32'd1);
            if (r == 9) chk("upd_busy_r9", {31'd0, busy}, 32'd0);
            if (r == 10) begin
                chk("upd_pend_r10", {31'd0, lat_pend}, 32'd1);
                chk("upd_active_r10", {26'd0, lat_active}, 32'd20);
            end
            if (r == 11) begin
                chk("upd_pend_r11", {31'd0, lat_pend}, 32'd0);
                chk("upd_active_r11", {26'd0, lat_active}, 32'd30);
            end
        end
        upd = 1'b0;
        chk("upd_count", cnt, 48);

        // Reset in the middle of a burst at L=40.
        set_lat(40);
        for (int r = 0; r <= 8; r++) begin
            cyc(); en = 8'hFF; #1;
        end
        chk("mid_vld_before_rst", {24'd0, rd_vld}, 32'hFF);
        cyc(); rst = 1'b1; en = '0; #1;
        chk("mid_rst_vld", {24'd0, rd_vld}, 32'd0);
        chk("mid_rst_ie", {24'd0, rd_ie}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pend", {31'd0, lat_pend}, 32'd0);
        chk("mid_rst_active", {26'd0, lat_active}, 32'd0);
        cyc(); cyc(); rst = 1'b0;
        cnt = 0;
        for (int r = 0; r < 15; r++) begin
            cyc(); #1;
            cnt += $countones(rd_vld) + $countones(rd_ie) + int'(busy);
        end
        chk("post_rst_residual", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
